sensor_log_mem: RTL
===================

Name: sensor_log_mem

Overview:
- Parametrised multi-channel sensor sample logger for the tag datapath. It sits between the ADC sampling path and the tag top's memory-read bit source.
- Each sample is stored as a record {sensor_time_stamp, ADC_data} in a per-channel circular buffer.
- On request, it serialises the newest N records of one channel MSB-first, driven by membitclk, and flags completion on memdatadone.
- It generalises the fixed 3-sensor, 8-bit handling to any channel count, data width, timestamp width and depth, and adds overwrite tracking.

Parameters:
- CHANNELS, 3, number of sensor channels (senscode width).
- ADC_W, 8, ADC sample width.
- TS_W, 8, timestamp width.
- DEPTH, 8, records per channel; must be a power of 2, at least 2.
- PTR_W, $clog2(DEPTH), pointer width.
- CNT_W, $clog2(DEPTH+1), fill/count width.
- CH_W, $clog2(CHANNELS), channel index width (minimum 1).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- ADC_data_ready, input, 1, one-cycle strobe: sample valid.
- ADC_data, input, ADC_W, sample value.
- senscode, input, CHANNELS, one-hot-or-multi channel select for the sample.
- sensor_time_stamp, input, TS_W, timestamp captured with the sample.
- log_clear, input, 1, pulse that empties all channels.
- rd_start, input, 1, pulse that starts a readout.
- rd_channel, input, CH_W, channel to read.
- rd_count, input, CNT_W, records requested.
- membitclk, input, 1, bit-advance strobe from top, sampled in clk.
- membitsrc, output, 1, serial data bit.
- memdatadone, output, 1, readout complete.
- rd_busy, output, 1, readout in progress.
- fill_level, output, CHANNELS*CNT_W, per-channel valid record count (channel 0 in the LSBs).
- overflow, output, CHANNELS, sticky per-channel overwrite flag.

Behaviour:
- Reset:
  - All pointers, fill counts, overflow flags, membitsrc, memdatadone and rd_busy are 0; FSM is in IDLE.
  - Storage contents are don't-care.
- Write:
  - On a clk edge with ADC_data_ready=1, every channel c with senscode[c]=1 stores the record at wr_ptr[c], then wr_ptr[c] increments mod DEPTH.
  - If fill[c] < DEPTH, fill[c] increments; otherwise fill stays at DEPTH and overflow[c] sets.
  - senscode=0 with ADC_data_ready=1 is ignored.
  - Writes are accepted in every FSM state, including to the channel under readout.
- log_clear:
  - Zeroes all wr_ptr, fill and overflow bits on the next edge.
  - Has priority over a simultaneous write; that write is dropped.
  - If a readout is active, it aborts to IDLE with memdatadone=1.
- Record width is REC_W = TS_W + ADC_W. Serial order is timestamp MSB first, then ADC MSB.
- membitclk:
  - Registered once; an advance is its 0->1 transition seen in clk (prev=0, cur=1).
  - Latency from the membitclk rising edge to membitsrc changing is 2 clk.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE:
    - rd_start=1 latches ch=rd_channel, n=min(rd_count, fill[ch]) and rd_idx=wr_ptr[ch]-1 (newest record).
    - If n=0, go to DONE. Otherwise go to LOAD and set rd_busy=1.
    - rd_channel >= CHANNELS is treated as n=0.
    - memdatadone clears on rd_start.
  - LOAD:
    - Shift register takes mem[ch][rd_idx], and membitsrc shows its MSB in the same cycle it is loaded.
    - bit_cnt is set to REC_W-1; go to SHIFT.
  - SHIFT, on each advance:
    - If bit_cnt>0: shift left, membitsrc shows the next bit, bit_cnt decrements.
    - If bit_cnt=0: n decrements and rd_idx decrements mod DEPTH. Go to LOAD if n is still >0, otherwise go to DONE.
    - LOAD presents the next record's MSB one clk after the advance that consumed the previous LSB.
  - DONE:
    - memdatadone=1, rd_busy=0, membitsrc=0; go to IDLE next cycle.
    - memdatadone stays high until the next rd_start, log_clear-free reset, or reset.
  - rd_start while busy is ignored.
- Readout reads records live. If a write lands in a slot before the reader loads it, the reader returns the new contents. The newest-first index is fixed at rd_start.
- Reset mid-readout returns everything to reset values immediately (asynchronous).
- All pointer arithmetic wraps modulo DEPTH. rd_count > DEPTH clamps to fill.

Test Plan:
- Reset, then write ch0 with ts=0x11, adc=0xA5; rd_start ch0, count 1; toggle membitclk 16 times:
  - Expect membitsrc sequence 0001_0001_1010_0101.
  - memdatadone=1 after the 16th advance; fill_level ch0=1.
- Write ch1 records (ts,adc) = (1,0x10), (2,0x20), (3,0x30); read ch1 count 2:
  - Expect record (3,0x30) then (2,0x20), then memdatadone.
  - Request count 5 → exactly 3 records are sent.
- Write ch2 10 times with DEPTH=8, adc=0..9:
  - fill ch2=8, overflow[2]=1; reading 8 records returns adc 9 down to 2.
- senscode=3'b101 with one sample: ch0 and ch2 fill become 1, ch1 stays 0. senscode=0 changes nothing.
- rd_start on an empty channel:
  - memdatadone=1 within 2 clk, no rd_busy pulse, membitsrc=0.
- Mid-readout checks:
  - Readout in SHIFT, then log_clear → memdatadone=1, all fills 0, overflow cleared.
  - Separately, reset during SHIFT → all outputs 0 while reset is high.

Source files
------------

// File: rtl/sensor_log_mem.sv
// Multi-channel sensor sample logger: per-channel circular buffers of {timestamp, ADC} records,
// with newest-first MSB-first serial readout advanced by membitclk rising edges.
module sensor_log_mem #(
    parameter int CHANNELS = 3,
    parameter int ADC_W    = 8,
    parameter int TS_W     = 8,
    parameter int DEPTH    = 8,
    parameter int PTR_W    = $clog2(DEPTH),
    parameter int CNT_W    = $clog2(DEPTH + 1),
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ADC_data_ready,
    input  logic [ADC_W-1:0]          ADC_data,
    input  logic [CHANNELS-1:0]       senscode,
    input  logic [TS_W-1:0]           sensor_time_stamp,
    input  logic                      log_clear,
    input  logic                      rd_start,
    input  logic [CH_W-1:0]           rd_channel,
    input  logic [CNT_W-1:0]          rd_count,
    input  logic                      membitclk,
    output logic                      membitsrc,
    output logic                      memdatadone,
    output logic                      rd_busy,
    output logic [CHANNELS*CNT_W-1:0] fill_level,
    output logic [CHANNELS-1:0]       overflow
);

    localparam int REC_W = TS_W + ADC_W;
    localparam int BC_W  = $clog2(REC_W);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

    state_e             state_q, state_d;
    logic [REC_W-1:0]   mem_q [CHANNELS][DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [CHANNELS];
    logic [CNT_W-1:0]   fill_q [CHANNELS];
    logic [CHANNELS-1:0] ovf_q;
    logic               mbc_q, mbc_prev_q;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic [BC_W-1:0]    bitcnt_q, bitcnt_d;
    logic [REC_W-1:0]   shreg_q, shreg_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   sel_fill, req_n;
    logic [PTR_W-1:0]   sel_wptr;
    logic [REC_W-1:0]   rec_rd;
    logic               advance;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                fill_q[c]   <= '0;
            end
            ovf_q <= '0;
        end else if (log_clear) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                fill_q[c]   <= '0;
            end
            ovf_q <= '0;
        end else if (ADC_data_ready) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (senscode[c]) begin
                    wr_ptr_q[c] <= wr_ptr_q[c] + PTR_W'(1);
                    if (fill_q[c] != CNT_W'(DEPTH)) fill_q[c] <= fill_q[c] + CNT_W'(1);
                    else                             ovf_q[c]  <= 1'b1;
                end
            end
        end
    end

    // Record storage carries no reset; its contents are only meaningful below the fill count.
    always_ff @(posedge clk) begin
        if (ADC_data_ready && !log_clear) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (senscode[c]) mem_q[c][wr_ptr_q[c]] <= {sensor_time_stamp, ADC_data};
            end
        end
    end

    // Out-of-range rd_channel matches no channel, so it reads as an empty channel.
    always_comb begin
        sel_fill = '0;
        sel_wptr = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (rd_channel == CH_W'(c)) begin
                sel_fill = fill_q[c];
                sel_wptr = wr_ptr_q[c];
            end
        end
    end

    always_comb begin
        rec_rd = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch_q == CH_W'(c)) rec_rd = mem_q[c][idx_q];
        end
    end

    assign req_n   = (rd_count < sel_fill) ? rd_count : sel_fill;
    assign advance = mbc_q & ~mbc_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mbc_q      <= 1'b0;
            mbc_prev_q <= 1'b0;
            ch_q       <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mbc_q      <= membitclk;
            mbc_prev_q <= mbc_q;
            ch_q       <= ch_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        n_d      = n_q;
        idx_d    = idx_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        done_d   = done_q;
        case (state_q)
            IDLE: begin
                if (rd_start && !log_clear) begin
                    ch_d    = rd_channel;
                    n_d     = req_n;
                    idx_d   = sel_wptr - PTR_W'(1);
                    shreg_d = '0;
                    if (req_n == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                        done_d  = 1'b0;
                    end
                end
            end
            LOAD: begin
                shreg_d  = rec_rd;
                bitcnt_d = BC_W'(REC_W - 1);
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (advance) begin
                    if (bitcnt_q != '0) begin
                        shreg_d  = shreg_q << 1;
                        bitcnt_d = bitcnt_q - BC_W'(1);
                    end else begin
                        n_d   = n_q - CNT_W'(1);
                        idx_d = idx_q - PTR_W'(1);
                        if (n_q == CNT_W'(1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            shreg_d = '0;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Clearing the log abandons an in-flight readout but still signals completion.
        if (log_clear && (state_q == LOAD || state_q == SHIFT)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            shreg_d = '0;
        end
    end

    assign membitsrc   = shreg_q[REC_W-1];
    assign memdatadone = done_q;
    assign rd_busy     = (state_q == LOAD) || (state_q == SHIFT);
    assign overflow    = ovf_q;

    always_comb begin
        fill_level = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) fill_level[c*CNT_W +: CNT_W] = fill_q[c];
    end

endmodule
